// File: rtl/sprite_bounce_gen_pkg.sv
// Shared VGA constants, pixel types and the per-axis bounce helper for the sprite generator.
package vga_pkg;

  localparam int H_RES = 640;
  localparam int V_RES = 480;
  localparam int X_W   = 11;
  localparam int Y_W   = 10;

  typedef logic [11:0] rgb12_t;

  typedef struct packed {
    logic de;
    logic hs;
    logic vs;
  } vid_ctl_t;

  localparam rgb12_t WHITE = 12'hFFF;
  localparam rgb12_t PALETTE [4] = '{12'hF80, 12'h0F0, 12'hF0F, 12'hFF0};

  // Returns {flip, next_pos}; a hit clamps flush to the edge rather than overshooting.
  function automatic logic [12:0] bounce_step(logic [11:0] pos, logic [11:0] size,
                                               logic [11:0] limit, logic [11:0] step,
                                               logic back);
    if (!back)
      return (pos + size + step >= limit) ? {1'b1, limit - size} : {1'b0, pos + step};
    return (pos <= step) ? 13'h1000 : {1'b0, pos - step};
  endfunction

endpackage

// File: rtl/sprite_bounce_gen_if.sv
// Timing-generator side inputs and pixel/sync outputs of the sprite generator.
interface sprite_bounce_gen_if;
  import vga_pkg::*;

  logic           i_pix_stb;
  logic [X_W-1:0] i_x;
  logic [Y_W-1:0] i_y;
  logic           i_disp_en;
  logic           i_hs;
  logic           i_vs;
  logic [3:0]     o_red;
  logic [3:0]     o_green;
  logic [3:0]     o_blue;
  logic           o_disp_en;
  logic           o_hs;
  logic           o_vs;
  logic           o_frame_tick;

  modport master (
    output i_pix_stb, i_x, i_y, i_disp_en, i_hs, i_vs,
    input  o_red, o_green, o_blue, o_disp_en, o_hs, o_vs, o_frame_tick
  );

  modport slave (
    input  i_pix_stb, i_x, i_y, i_disp_en, i_hs, i_vs,
    output o_red, o_green, o_blue, o_disp_en, o_hs, o_vs, o_frame_tick
  );
endinterface

// File: rtl/sprite_bounce_gen_motion.sv
// Per-frame box motion: vsync falling-edge detect, position, bounce direction and colour index.
module sprite_motion
  import vga_pkg::*;
#(
  parameter int BOX_W = 64,
  parameter int BOX_H = 48,
  parameter int STEP  = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           vs,
  output logic [X_W-1:0] box_x,
  output logic [Y_W-1:0] box_y,
  output logic [1:0]     idx,
  output logic           frame_tick
);

  localparam logic [11:0] BW  = 12'(BOX_W);
  localparam logic [11:0] BH  = 12'(BOX_H);
  localparam logic [11:0] STP = 12'(STEP);
  localparam logic [11:0] HR  = 12'(H_RES);
  localparam logic [11:0] VR  = 12'(V_RES);
  localparam logic [X_W-1:0] X_START = X_W'((H_RES - BOX_W) / 2);
  localparam logic [Y_W-1:0] Y_START = Y_W'((V_RES - BOX_H) / 2);

  logic        vs_q, left, up, tick, flip_x, flip_y;
  logic [11:0] nx, ny;

  // Only the vsync falling edge moves the box, so a frame never shows two positions.
  assign tick = vs_q & ~vs;
  assign {flip_x, nx} = bounce_step(12'(box_x), BW, HR, STP, left);
  assign {flip_y, ny} = bounce_step(12'(box_y), BH, VR, STP, up);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vs_q       <= 1'b1;
      frame_tick <= 1'b0;
      box_x      <= X_START;
      box_y      <= Y_START;
      left       <= 1'b0;
      up         <= 1'b0;
      idx        <= '0;
    end else begin
      vs_q       <= vs;
      frame_tick <= tick;
      if (tick) begin
        box_x <= nx[X_W-1:0];
        box_y <= ny[Y_W-1:0];
        left  <= left ^ flip_x;
        up    <= up ^ flip_y;
        // A corner hit flips both axes but advances the colour only once.
        if (flip_x | flip_y) idx <= idx + 2'd1;
      end
    end
  end

endmodule

// File: rtl/sprite_bounce_gen.sv
// Bouncing bordered box over a solid background; two strobe-gated stages keep RGB and syncs aligned.
module sprite_bounce_gen
  import vga_pkg::*;
#(
  parameter int     BOX_W  = 64,
  parameter int     BOX_H  = 48,
  parameter int     STEP   = 2,
  parameter int     BORDER = 2,
  parameter rgb12_t BG_RGB = 12'h028
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  sprite_bounce_gen_if.slave  bus
);

  localparam logic [11:0] BW    = 12'(BOX_W);
  localparam logic [11:0] BH    = 12'(BOX_H);
  localparam logic [11:0] BRD   = 12'(BORDER);
  localparam logic [11:0] BW_IN = 12'(BOX_W - BORDER);
  localparam logic [11:0] BH_IN = 12'(BOX_H - BORDER);
  localparam vid_ctl_t    CTL_RST = '{de: 1'b0, hs: 1'b1, vs: 1'b1};

  logic [X_W-1:0] box_x;
  logic [Y_W-1:0] box_y;
  logic [1:0]     idx;
  logic           frame_tick;

  sprite_motion #(.BOX_W(BOX_W), .BOX_H(BOX_H), .STEP(STEP)) u_motion (
    .clk        (i_clk),
    .rst_n      (i_rst_n),
    .vs         (bus.i_vs),
    .box_x      (box_x),
    .box_y      (box_y),
    .idx        (idx),
    .frame_tick (frame_tick)
  );

  logic [11:0] px, py, bx, by;
  logic        in_box, on_border;

  assign px = 12'(bus.i_x);
  assign py = 12'(bus.i_y);
  assign bx = 12'(box_x);
  assign by = 12'(box_y);

  assign in_box    = (px >= bx) && (px < bx + BW) && (py >= by) && (py < by + BH);
  assign on_border = in_box && ((px < bx + BRD) || (px >= bx + BW_IN) ||
                                (py < by + BRD) || (py >= by + BH_IN));

  vid_ctl_t s1_ctl, s2_ctl;
  logic     s1_in, s1_border;
  rgb12_t   s2_rgb, pix_rgb;

  // Colour index is sampled at S2 time; blanking is folded in here so S2 loads it directly.
  always_comb begin
    pix_rgb = BG_RGB;
    if (!s1_ctl.de)     pix_rgb = '0;
    else if (s1_border) pix_rgb = WHITE;
    else if (s1_in)     pix_rgb = PALETTE[idx];
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      s1_ctl    <= CTL_RST;
      s1_in     <= 1'b0;
      s1_border <= 1'b0;
      s2_ctl    <= CTL_RST;
      s2_rgb    <= '0;
    end else if (bus.i_pix_stb) begin
      s1_ctl    <= '{de: bus.i_disp_en, hs: bus.i_hs, vs: bus.i_vs};
      s1_in     <= in_box;
      s1_border <= on_border;
      s2_ctl    <= s1_ctl;
      s2_rgb    <= pix_rgb;
    end
  end

  assign bus.o_red        = s2_rgb[11:8];
  assign bus.o_green      = s2_rgb[7:4];
  assign bus.o_blue       = s2_rgb[3:0];
  assign bus.o_disp_en    = s2_ctl.de;
  assign bus.o_hs         = s2_ctl.hs;
  assign bus.o_vs         = s2_ctl.vs;
  assign bus.o_frame_tick = frame_tick;

endmodule
